// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states
// and the default datapath width.
package alu_arb_pkg;

    localparam int DW_DEFAULT = 8;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: AND/OR/ADD/SUB with carry, zero and
// illegal-opcode flags.
module alu_core
    import alu_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          zero,
    output logic          cout,
    output logic          err
);

    logic [DW:0] sum;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        sum    = '0;
        result = '0;
        cout   = 1'b0;
        err    = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
                sum           = {1'b0, a} + {1'b0, b};
                {cout, result} = sum;
            end
            // Two's-complement subtract; carry-out high means no borrow.
            OP_SUB: begin
                sum           = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
                {cout, result} = sum;
            end
            default: err = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single ALU; one transaction in flight,
// response held until the consumer accepts it.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [2:0]    req0_op,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [2:0]    req1_op,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_result,
    output logic          rsp_zero,
    output logic          rsp_cout,
    output logic          rsp_err
);

    state_t        state;
    logic          last;
    logic          gnt0;
    logic          gnt1;
    logic [2:0]    cap_op;
    logic [DW-1:0] cap_a;
    logic [DW-1:0] cap_b;
    logic          cap_id;

    logic [DW-1:0] core_result;
    logic          core_zero;
    logic          core_cout;
    logic          core_err;

    // On a tie the requester not served last wins; last==1 means requester 1.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == S_IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last;
                gnt1 = !last;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    alu_core #(.DW(DW)) u_core (
        .op     (cap_op),
        .a      (cap_a),
        .b      (cap_b),
        .result (core_result),
        .zero   (core_zero),
        .cout   (core_cout),
        .err    (core_err)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last       <= 1'b1;
            cap_op     <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        cap_op <= gnt1 ? req1_op : req0_op;
                        cap_a  <= gnt1 ? req1_a  : req0_a;
                        cap_b  <= gnt1 ? req1_b  : req0_b;
                        cap_id <= gnt1;
                        last   <= gnt1;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result <= core_result;
                    rsp_zero   <= core_zero;
                    rsp_cout   <= core_cout;
                    rsp_err    <= core_err;
                    rsp_id     <= cap_id;
                    rsp_valid  <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed corner cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [2:0] req0_op = '0;
    logic [7:0] req0_a = '0;
    logic [7:0] req0_b = '0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [2:0] req1_op = '0;
    logic [7:0] req1_a = '0;
    logic [7:0] req1_b = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_id;
    logic [7:0] rsp_result;
    logic       rsp_zero;
    logic       rsp_cout;
    logic       rsp_err;

    int n_checks = 0;
    int n_err    = 0;
    int last_served = 1;
    int grants[$];

    always #5 clk = ~clk;

    alu_arbiter #(.DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_cout   (rsp_cout),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU from the arithmetic definitions; returns {err, cout, zero, result}.
    function automatic logic [10:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, r;
        logic c, e;
        ia = int'(a);
        ib = int'(b);
        r = 0;
        c = 1'b0;
        e = 1'b0;
        case (int'(op))
            0: r = int'(a & b);
            1: r = int'(a | b);
            2: begin r = (ia + ib) % 256; c = (ia + ib) > 255; end
            3: begin r = (ia - ib + 256) % 256; c = (ia >= ib); end
            default: begin r = 0; e = 1'b1; end
        endcase
        return {e, c, (r == 0), r[7:0]};
    endfunction

    function automatic int pick_winner(input logic v0, input logic v1);
        if (v0 && v1) return (last_served == 0) ? 1 : 0;
        return v0 ? 0 : 1;
    endfunction

    // One full transaction starting in IDLE; at least one valid must be set.
    task automatic do_txn(input logic v0, input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                          input logic v1, input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                          input int hold);
        int w;
        logic [10:0] exp;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        #1;
        w = pick_winner(v0, v1);
        exp = (w == 1) ? alu_model(op1, a1, b1) : alu_model(op0, a0, b0);
        check("grant_ready0", req0_ready, w == 0);
        check("grant_ready1", req1_ready, w == 1);
        last_served = w;
        grants.push_back(w);
        @(posedge clk); #1;
        req0_op = 3'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_op = 3'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
        check("exec_readies", {req0_ready, req1_ready}, 2'b00);
        check("exec_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        check("done_rsp_valid", rsp_valid, 1'b1);
        check("rsp_id", rsp_id, w);
        check("rsp_result", rsp_result, exp[7:0]);
        check("rsp_zero", rsp_zero, exp[8]);
        check("rsp_cout", rsp_cout, exp[9]);
        check("rsp_err", rsp_err, exp[10]);
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_payload", {rsp_id, rsp_err, rsp_cout, rsp_zero, rsp_result}, {w[0], exp});
            check("hold_readies", {req0_ready, req1_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("release_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        int base;
        logic v0, v1;

        // Reset with requests pending: no ready may be raised while rst is high.
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        @(posedge clk); #1;
        check("rst_readies", {req0_ready, req1_ready}, 2'b00);
        @(posedge clk); #1;
        check("rst_rsp", {rsp_valid, rsp_id, rsp_zero, rsp_cout, rsp_err, rsp_result}, 13'h0);
        rsp_ready = 1'b0;
        rst = 1'b0;
        last_served = 1;

        // Continuous tie: grants must alternate starting with requester 0.
        base = grants.size();
        for (int i = 0; i < 4; i++)
            do_txn(1'b1, 3'b010, 8'hF0, 8'h20, 1'b1, 3'b011, 8'h05, 8'h05, 0);
        check("rr_g0", grants[base],     0);
        check("rr_g1", grants[base + 1], 1);
        check("rr_g2", grants[base + 2], 0);
        check("rr_g3", grants[base + 3], 1);

        // Directed arithmetic corners.
        do_txn(1'b1, 3'b010, 8'hF0, 8'h20, 1'b0, 3'b000, 8'h00, 8'h00, 0);
        do_txn(1'b0, 3'b000, 8'h00, 8'h00, 1'b1, 3'b011, 8'h05, 8'h05, 0);
        do_txn(1'b0, 3'b000, 8'h00, 8'h00, 1'b1, 3'b011, 8'h03, 8'h04, 0);
        do_txn(1'b1, 3'b110, 8'hFF, 8'h12, 1'b0, 3'b000, 8'h00, 8'h00, 0);
        do_txn(1'b1, 3'b000, 8'hAA, 8'h55, 1'b0, 3'b000, 8'h00, 8'h00, 0);

        // Backpressure for five cycles; rsp_ready pulses are ignored while idle.
        do_txn(1'b1, 3'b001, 8'h0C, 8'h30, 1'b1, 3'b010, 8'hFF, 8'h01, 5);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        #1;
        check("idle_readies", {req0_ready, req1_ready}, 2'b00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("idle_no_rsp", rsp_valid, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v1 = 1'b1;
            do_txn(v0, 3'($urandom), 8'($urandom), 8'($urandom),
                   v1, 3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end

        // Make requester 0 the last served, then reset in DONE.
        do_txn(1'b1, 3'b010, 8'h01, 8'h02, 1'b0, 3'b000, 8'h00, 8'h00, 0);
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = 8'h11; req0_b = 8'h22;
        req1_valid = 1'b1; req1_op = 3'b001; req1_a = 8'h33; req1_b = 8'h44;
        #1;
        check("pre_rst_grant1", req1_ready, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_done", rsp_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_done_valid", rsp_valid, 1'b0);
        check("rst_done_readies", {req0_ready, req1_ready}, 2'b00);
        @(posedge clk); #1;
        check("rst_still_quiet", rsp_valid, 1'b0);
        rst = 1'b0;
        last_served = 1;
        do_txn(1'b1, 3'b011, 8'h10, 8'h01, 1'b1, 3'b000, 8'hFF, 8'hFF, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
